// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register file: FunSel encodings
// and the next-value function used by every register cell.
package regfile_pkg;

    // FunSel operation encodings
    localparam logic [2:0] FS_DEC  = 3'b000;
    localparam logic [2:0] FS_INC  = 3'b001;
    localparam logic [2:0] FS_LOAD = 3'b010;
    localparam logic [2:0] FS_CLR  = 3'b011;
    localparam logic [2:0] FS_LD8  = 3'b100;
    localparam logic [2:0] FS_LD16 = 3'b101;
    localparam logic [2:0] FS_SHL8 = 3'b110;
    localparam logic [2:0] FS_SX16 = 3'b111;

    // The next-value function works on a fixed wide container and masks the
    // result down to the caller's width; cells refuse widths beyond this.
    localparam int REGFILE_MAX_W = 128;

    localparam logic [REGFILE_MAX_W-1:0] REGFILE_ONE = REGFILE_MAX_W'(1);

    typedef struct packed {
        logic                     wrap;
        logic [REGFILE_MAX_W-1:0] value;
    } regfile_next_t;

    // Next register value for one operation; wrap flags an increment from
    // all-ones or a decrement from zero at the given width.
    function automatic regfile_next_t regfile_next(
        input logic [REGFILE_MAX_W-1:0] val,
        input logic [REGFILE_MAX_W-1:0] data,
        input logic [2:0]               fsel,
        input int unsigned              width
    );
        logic [REGFILE_MAX_W-1:0] mask;
        logic [REGFILE_MAX_W-1:0] v;
        regfile_next_t            r;
        mask = '1;
        mask = mask >> (REGFILE_MAX_W - width);
        v    = val & mask;
        r.wrap  = 1'b0;
        r.value = '0;
        case (fsel)
            FS_DEC: begin
                r.value = (v - REGFILE_ONE) & mask;
                r.wrap  = (v == '0);
            end
            FS_INC: begin
                r.value = (v + REGFILE_ONE) & mask;
                r.wrap  = (v == mask);
            end
            FS_LOAD: r.value = data & mask;
            FS_CLR:  r.value = '0;
            FS_LD8:  r.value = REGFILE_MAX_W'(data[7:0]);
            FS_LD16: r.value = REGFILE_MAX_W'(data[15:0]);
            FS_SHL8: r.value = ((v << 8) | REGFILE_MAX_W'(data[7:0])) & mask;
            FS_SX16: r.value = {{(REGFILE_MAX_W-16){data[15]}}, data[15:0]} & mask;
            default: r.value = v;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/param_register_cell.sv
// One WIDTH-bit register with its sticky wrap flag. Exposes the computed
// next value so the top level can offer a write-to-read bypass.
module param_register_cell
    import regfile_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] data,
    input  logic [2:0]       fsel,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] nxt,
    output logic             wrap
);

    generate
        if (WIDTH < 16 || WIDTH > REGFILE_MAX_W) begin : g_bad_width
            $error("param_register_cell: WIDTH out of supported range");
        end
    endgenerate

    regfile_next_t r;

    // Evaluate the selected operation against this register's own value
    always_comb begin
        r = regfile_next(REGFILE_MAX_W'(q), REGFILE_MAX_W'(data), fsel, WIDTH);
    end

    assign nxt = r.value[WIDTH-1:0];

    generate
        if (WIDTH < REGFILE_MAX_W) begin : g_hi
            logic unused_hi;
            assign unused_hi = ^r.value[REGFILE_MAX_W-1:WIDTH];
        end
    endgenerate

    // Register and sticky flag update; reset wins over any write
    always_ff @(posedge clock) begin
        if (reset) begin
            q    <= '0;
            wrap <= 1'b0;
        end else if (en) begin
            q <= nxt;
            if (fsel == FS_CLR) begin
                wrap <= 1'b0;
            end else if (r.wrap) begin
                wrap <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/param_register_file.sv
// Parametrised register file: NUM_REGS cells sharing one masked write path,
// two combinational read ports with optional write-to-read bypass, and a
// flat view of every register for debug.
module param_register_file
    import regfile_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int NUM_REGS = 8,
    parameter int SEL_W    = $clog2(NUM_REGS),
    parameter int BYPASS   = 0
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic [WIDTH-1:0]          I,
    input  logic [2:0]                FunSel,
    input  logic [NUM_REGS-1:0]       RegEn,
    input  logic [SEL_W-1:0]          OutASel,
    input  logic [SEL_W-1:0]          OutBSel,
    output logic [WIDTH-1:0]          OutA,
    output logic [WIDTH-1:0]          OutB,
    output logic [NUM_REGS-1:0]       Wrap,
    output logic [NUM_REGS*WIDTH-1:0] RegQ
);

    localparam int TAB_N = 1 << SEL_W;

    logic [WIDTH-1:0] q    [NUM_REGS];
    logic [WIDTH-1:0] nxt  [NUM_REGS];
    logic [WIDTH-1:0] view [NUM_REGS];
    logic [WIDTH-1:0] tab  [TAB_N];

    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_cell
            param_register_cell #(.WIDTH(WIDTH)) u_cell (
                .clock (Clock),
                .reset (Reset),
                .en    (RegEn[g]),
                .data  (I),
                .fsel  (FunSel),
                .q     (q[g]),
                .nxt   (nxt[g]),
                .wrap  (Wrap[g])
            );
            assign RegQ[g*WIDTH +: WIDTH] = q[g];
        end
    endgenerate

    // Value each read port sees per register: stored value, or with bypass the
    // value this cycle's write (or reset) is about to commit
    always_comb begin
        for (int k = 0; k < NUM_REGS; k++) begin
            view[k] = q[k];
            if (BYPASS != 0) begin
                if (Reset) begin
                    view[k] = '0;
                end else if (RegEn[k]) begin
                    view[k] = nxt[k];
                end
            end
        end
    end

    // Select table padded with zeros so out-of-range selects read 0
    generate
        for (g = 0; g < TAB_N; g++) begin : g_tab
            if (g < NUM_REGS) begin : g_real
                assign tab[g] = view[g];
            end else begin : g_pad
                assign tab[g] = '0;
            end
        end
    endgenerate

    assign OutA = tab[OutASel];
    assign OutB = tab[OutBSel];

endmodule

// File: tb/tb_param_register_file.sv
// Bench for param_register_file: one default instance (32 x 8, no bypass) and
// one swept instance (16 x 6, bypass), an arithmetic model of both, a per-cycle
// compare process and directed literal checks.
module tb_param_register_file;

    localparam int AW = 32;
    localparam int AN = 8;
    localparam int BW = 16;
    localparam int BN = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance A signals
    logic          a_reset;
    logic [AW-1:0] a_i;
    logic [2:0]    a_fs;
    logic [AN-1:0] a_en;
    logic [2:0]    a_sa, a_sb;
    logic [AW-1:0] a_outa, a_outb;
    logic [AN-1:0] a_wrap;
    logic [AN*AW-1:0] a_regq;

    // instance B signals
    logic          b_reset;
    logic [BW-1:0] b_i;
    logic [2:0]    b_fs;
    logic [BN-1:0] b_en;
    logic [2:0]    b_sa, b_sb;
    logic [BW-1:0] b_outa, b_outb;
    logic [BN-1:0] b_wrap;
    logic [BN*BW-1:0] b_regq;

    param_register_file #(.WIDTH(AW), .NUM_REGS(AN), .BYPASS(0)) dut_a (
        .Clock(clk), .Reset(a_reset), .I(a_i), .FunSel(a_fs), .RegEn(a_en),
        .OutASel(a_sa), .OutBSel(a_sb), .OutA(a_outa), .OutB(a_outb),
        .Wrap(a_wrap), .RegQ(a_regq)
    );

    param_register_file #(.WIDTH(BW), .NUM_REGS(BN), .BYPASS(1)) dut_b (
        .Clock(clk), .Reset(b_reset), .I(b_i), .FunSel(b_fs), .RegEn(b_en),
        .OutASel(b_sa), .OutBSel(b_sb), .OutA(b_outa), .OutB(b_outb),
        .Wrap(b_wrap), .RegQ(b_regq)
    );

    int errors = 0;
    int checks = 0;
    bit checking = 1'b0;

    // model state
    logic [63:0] ma  [AN];
    logic        mwa [AN];
    logic [63:0] mb  [BN];
    logic        mwb [BN];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Arithmetic reading of the operation table at width w
    function automatic logic [63:0] mnext(input int w, input logic [63:0] v,
                                          input logic [63:0] i, input logic [2:0] fs);
        logic [63:0] allones;
        allones = (64'd1 << w) - 64'd1;
        case (fs)
            3'd0: return (v == 64'd0) ? allones : v - 64'd1;
            3'd1: return (v == allones) ? 64'd0 : v + 64'd1;
            3'd2: return i & allones;
            3'd3: return 64'd0;
            3'd4: return i % 64'd256;
            3'd5: return i % 64'd65536;
            3'd6: return (v * 64'd256 + i % 64'd256) & allones;
            default: return i[15] ? (allones - 64'd65535) + i % 64'd65536 : i % 64'd65536;
        endcase
    endfunction

    function automatic logic mwrap(input int w, input logic old_flag, input logic [63:0] v,
                                   input logic [2:0] fs);
        logic [63:0] allones;
        allones = (64'd1 << w) - 64'd1;
        if (fs == 3'd3) return 1'b0;
        if (fs == 3'd1 && v == allones) return 1'b1;
        if (fs == 3'd0 && v == 64'd0) return 1'b1;
        return old_flag;
    endfunction

    // What a bypassed port of B must show for a given select
    function automatic logic [63:0] bview(input logic [2:0] sel);
        if (sel >= BN) return 64'd0;
        if (b_reset) return 64'd0;
        if (b_en[sel]) return mnext(BW, mb[sel], 64'(b_i), b_fs);
        return mb[sel];
    endfunction

    // model update on each rising edge
    always @(posedge clk) begin
        for (int k = 0; k < AN; k++) begin
            if (a_reset) begin
                ma[k]  <= 64'd0;
                mwa[k] <= 1'b0;
            end else if (a_en[k]) begin
                ma[k]  <= mnext(AW, ma[k], 64'(a_i), a_fs);
                mwa[k] <= mwrap(AW, mwa[k], ma[k], a_fs);
            end
        end
        for (int k = 0; k < BN; k++) begin
            if (b_reset) begin
                mb[k]  <= 64'd0;
                mwb[k] <= 1'b0;
            end else if (b_en[k]) begin
                mb[k]  <= mnext(BW, mb[k], 64'(b_i), b_fs);
                mwb[k] <= mwrap(BW, mwb[k], mb[k], b_fs);
            end
        end
    end

    // per-cycle compare against the model
    always @(negedge clk) begin
        if (checking) begin
            for (int k = 0; k < AN; k++) begin
                check($sformatf("a_regq[%0d]", k), 64'(a_regq[k*AW +: AW]), ma[k]);
                check($sformatf("a_wrap[%0d]", k), 64'(a_wrap[k]), 64'(mwa[k]));
            end
            check("a_outa", 64'(a_outa), ma[a_sa]);
            check("a_outb", 64'(a_outb), ma[a_sb]);
            for (int k = 0; k < BN; k++) begin
                check($sformatf("b_regq[%0d]", k), 64'(b_regq[k*BW +: BW]), mb[k]);
                check($sformatf("b_wrap[%0d]", k), 64'(b_wrap[k]), 64'(mwb[k]));
            end
            check("b_outa", 64'(b_outa), bview(b_sa));
            check("b_outb", 64'(b_outb), bview(b_sb));
        end
    end

    task automatic drive_a(input logic rst, input logic [AN-1:0] en, input logic [2:0] fs,
                           input logic [AW-1:0] i, input logic [2:0] sa, input logic [2:0] sb);
        a_reset = rst; a_en = en; a_fs = fs; a_i = i; a_sa = sa; a_sb = sb;
    endtask

    task automatic drive_b(input logic rst, input logic [BN-1:0] en, input logic [2:0] fs,
                           input logic [BW-1:0] i, input logic [2:0] sa, input logic [2:0] sb);
        b_reset = rst; b_en = en; b_fs = fs; b_i = i; b_sa = sa; b_sb = sb;
    endtask

    task automatic tick();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive_a(1'b1, '0, 3'd2, '0, 3'd0, 3'd7);
        drive_b(1'b1, '0, 3'd2, '0, 3'd0, 3'd5);
        @(posedge clk);
        #1;
        checking = 1'b1;

        // reset state
        drive_a(1'b0, 8'h00, 3'd2, 32'h0, 3'd0, 3'd7);
        drive_b(1'b0, 6'h00, 3'd2, 16'h0, 3'd7, 3'd6);
        #1;
        check("rst_outa", 64'(a_outa), 64'h0);
        check("rst_outb", 64'(a_outb), 64'h0);
        check("rst_regq", 64'(|a_regq), 64'h0);
        check("rst_wrap", 64'(a_wrap), 64'h0);
        check("b_oor_a", 64'(b_outa), 64'h0);
        check("b_oor_b", 64'(b_outb), 64'h0);
        tick();

        // masked load into registers 0 and 2
        drive_a(1'b0, 8'h05, 3'd2, 32'hDEADBEEF, 3'd2, 3'd0);
        tick();
        drive_a(1'b0, 8'h00, 3'd2, 32'h0, 3'd2, 3'd0);
        #1;
        check("ld_outa", 64'(a_outa), 64'hDEADBEEF);
        check("ld_outb", 64'(a_outb), 64'hDEADBEEF);
        check("ld_reg1", 64'(a_regq[63:32]), 64'h0);

        // increment wrap on register 1
        drive_a(1'b0, 8'h02, 3'd2, 32'hFFFFFFFF, 3'd1, 3'd1);
        tick();
        drive_a(1'b0, 8'h02, 3'd1, 32'h0, 3'd1, 3'd3);
        tick();
        drive_a(1'b0, 8'h00, 3'd2, 32'h0, 3'd1, 3'd3);
        #1;
        check("inc_wrap_val", 64'(a_outa), 64'h0);
        check("inc_wrap_flag", 64'(a_wrap[1]), 64'h1);
        drive_a(1'b0, 8'h02, 3'd1, 32'h0, 3'd1, 3'd3);
        tick();
        drive_a(1'b0, 8'h00, 3'd2, 32'h0, 3'd1, 3'd3);
        #1;
        check("inc_again_val", 64'(a_outa), 64'h1);
        check("inc_sticky", 64'(a_wrap[1]), 64'h1);
        drive_a(1'b0, 8'h02, 3'd3, 32'h0, 3'd1, 3'd3);
        tick();
        drive_a(1'b0, 8'h00, 3'd2, 32'h0, 3'd1, 3'd3);
        #1;
        check("clr_flag", 64'(a_wrap[1]), 64'h0);

        // decrement wrap on register 3
        drive_a(1'b0, 8'h08, 3'd0, 32'h0, 3'd3, 3'd3);
        tick();
        drive_a(1'b0, 8'h00, 3'd2, 32'h0, 3'd3, 3'd4);
        #1;
        check("dec_val", 64'(a_outa), 64'hFFFFFFFF);
        check("dec_flag", 64'(a_wrap[3]), 64'h1);

        // width operations on register 4
        drive_a(1'b0, 8'h10, 3'd7, 32'h00008123, 3'd4, 3'd4);
        tick();
        #1;
        check("sx16", 64'(a_regq[159:128]), 64'hFFFF8123);
        drive_a(1'b0, 8'h10, 3'd6, 32'h00000045, 3'd4, 3'd4);
        tick();
        #1;
        check("shl8", 64'(a_regq[159:128]), 64'hFF812345);
        drive_a(1'b0, 8'h10, 3'd4, 32'h000001FF, 3'd4, 3'd4);
        tick();
        drive_a(1'b0, 8'h00, 3'd2, 32'h0, 3'd4, 3'd4);
        #1;
        check("ld8", 64'(a_outa), 64'h000000FF);

        // increment every register at once
        drive_a(1'b0, 8'hFF, 3'd1, 32'h0, 3'd0, 3'd3);
        tick();
        drive_a(1'b0, 8'h00, 3'd2, 32'h0, 3'd0, 3'd3);
        #1;
        check("multi_r0", 64'(a_outa), 64'hDEADBEF0);
        check("multi_r3", 64'(a_outb), 64'h0);
        check("multi_r4", 64'(a_regq[159:128]), 64'h100);
        check("multi_w3", 64'(a_wrap[3]), 64'h1);

        // reset with a write pending
        drive_a(1'b1, 8'hFF, 3'd1, 32'h0, 3'd0, 3'd3);
        tick();
        drive_a(1'b0, 8'h00, 3'd2, 32'h0, 3'd0, 3'd3);
        #1;
        check("a_rst2_regq", 64'(|a_regq), 64'h0);
        check("a_rst2_wrap", 64'(a_wrap), 64'h0);

        // instance B: same-cycle bypass of a load
        drive_b(1'b0, 6'h20, 3'd2, 16'h1234, 3'd7, 3'd5);
        #1;
        check("byp_load", 64'(b_outb), 64'h1234);
        check("byp_oor", 64'(b_outa), 64'h0);
        check("byp_reg_old", 64'(b_regq[95:80]), 64'h0);
        tick();
        drive_b(1'b0, 6'h20, 3'd1, 16'h0, 3'd5, 3'd5);
        tick();
        drive_b(1'b0, 6'h20, 3'd1, 16'h0, 3'd5, 3'd5);
        #1;
        check("byp_inc", 64'(b_outb), 64'h1236);
        tick();
        drive_b(1'b1, 6'h20, 3'd1, 16'h0, 3'd5, 3'd5);
        #1;
        check("byp_rst_a", 64'(b_outa), 64'h0);
        check("byp_rst_b", 64'(b_outb), 64'h0);
        tick();
        drive_b(1'b0, 6'h00, 3'd2, 16'h0, 3'd5, 3'd5);
        #1;
        check("b_after_rst", 64'(b_outb), 64'h0);
        check("b_after_rst_q", 64'(b_regq[95:80]), 64'h0);

        // 16-bit wrap and width ops
        drive_b(1'b0, 6'h01, 3'd2, 16'hFFFF, 3'd0, 3'd1);
        tick();
        drive_b(1'b0, 6'h01, 3'd1, 16'h0, 3'd0, 3'd1);
        tick();
        drive_b(1'b0, 6'h02, 3'd7, 16'h8123, 3'd0, 3'd1);
        tick();
        drive_b(1'b0, 6'h02, 3'd6, 16'h0045, 3'd0, 3'd1);
        tick();
        drive_b(1'b0, 6'h00, 3'd2, 16'h0, 3'd0, 3'd1);
        #1;
        check("b_wrap0", 64'(b_wrap[0]), 64'h1);
        check("b_reg0", 64'(b_outa), 64'h0);
        check("b_shl8", 64'(b_outb), 64'h2345);

        tick();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
